fir_job_arbiter: RTL and testbench
==================================

Name: fir_job_arbiter

Overview:
- Shares the single FIR accelerator between two independent requesters, e.g. HPS software and a streaming DMA front-end.
- Each requester uses a 4-phase start/done handshake. The block drives the accelerator's level start input and monitors its finish output.
- Provides round-robin fairness, finish-signal blanking, a watchdog timeout and a completed-job counter.
- Sits between the requesters and the accelerator's start/finish conduit; it has no Avalon data path.

Parameters:
- BLANK_CYCLES, 3: cycles after acc_start rises during which acc_finish is ignored. The accelerator's stale finish clears 2 cycles after it sees start.
- TIMEOUT_CYCLES, 65535: maximum cycles in START+RUN before the watchdog aborts the job.
- CNT_W, 16: width of the job counter.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req0_start  in  1  requester 0 job request, level.
- req0_done  out  1  requester 0 completion, held until req0_start drops.
- req1_start  in  1  requester 1 job request, level.
- req1_done  out  1  requester 1 completion, held until req1_start drops.
- acc_start  out  1  to accelerator start conduit.
- acc_finish  in  1  from accelerator finish conduit.
- grant  out  2  one-hot owner of the current job; 00 when idle.
- busy  out  1  high in every state except IDLE.
- job_err  out  1  high together with reqN_done when the job was aborted by timeout.
- timeout_sticky  out  1  set on any timeout; cleared only by reset.
- jobs_done  out  CNT_W  count of successfully finished jobs, wraps modulo 2^CNT_W.

Behaviour:
- Reset values (asynchronous, all outputs): acc_start=0, reqN_done=0, grant=00, busy=0, job_err=0, timeout_sticky=0, jobs_done=0, state=IDLE, rr_last=1 so requester 0 wins the first tie. Reset mid-job drops acc_start immediately and abandons the job.
- FSM, one-hot encoded: IDLE, START, RUN, RELEASE, DONE.
- IDLE:
  - Samples req0_start and req1_start.
  - One request: grant it. Both requests: grant the requester other than rr_last.
  - On grant: register grant, go to START.
- START:
  - acc_start=1 from the first cycle in START, so acc_start rises 1 cycle after the request is sampled.
  - The blanking counter runs for BLANK_CYCLES cycles, then go to RUN. acc_finish is ignored throughout START.
- RUN:
  - acc_start held at 1.
  - On acc_finish=1: go to RELEASE with job_err=0 and increment jobs_done.
- Watchdog:
  - The counter runs from START entry through RUN.
  - On reaching TIMEOUT_CYCLES: go to RELEASE with job_err=1, set timeout_sticky, do not increment jobs_done.
  - If finish and timeout occur in the same cycle, finish wins.
- RELEASE: acc_start=0 for exactly 1 cycle, then go to DONE. The accelerator only returns to its waiting state after start drops.
- DONE:
  - Assert reqN_done for the granted requester; job_err reflects the job outcome.
  - Hold both until that requester's start is sampled low.
  - Then in the same cycle: clear done, clear job_err, grant=00, rr_last=granted requester, go to IDLE.
- IDLE re-arbitrates on the next cycle. A new acc_start therefore cannot rise earlier than 2 cycles after the previous requester's start is sampled low.
- A requester dropping start before done is ignored; the job runs to completion and done is still issued, then clears on the next cycle because start is low.
- The non-granted requester's start may stay high indefinitely; it is serviced next. Strict alternation holds under continuous contention.
- busy = (state != IDLE).

Decomposition:
- Package fir_ctrl_pkg contains the one-hot state constants (IDLE=5'b00001 … DONE=5'b10000) and the default BLANK/TIMEOUT values.
- Sub-module fir_rr_arb: 2-input round-robin combinational pick from {req, rr_last}, giving a one-hot grant and a valid flag. Both the rr_last register and the FSM stay in fir_job_arbiter.

Test Plan:
1. Reset sequence: reset low 3 cycles with req0_start=1, then released → all outputs at reset values during reset. acc_start=1 at the 2nd clk after release, grant=01.
2. Single job, req0: the accelerator model raises finish 300 cycles after start and holds it until start drops → acc_start falls 1 cycle after finish is seen. req0_done=1 and job_err=0 hold until req0_start=0. jobs_done=1, then busy=0.
3. Stale finish: acc_finish held 1 from before the job and cleared 2 cycles after acc_start rises → no early completion. The job completes only on the model's real finish.
4. Contention: req0 and req1 both held high for 4 jobs, each requester dropping start after its done → grants 01,10,01,10 and jobs_done=4.
5. Timeout with TIMEOUT_CYCLES=50 and the model never finishing → acc_start falls at cycle 50 after START entry, req1_done=1 with job_err=1, timeout_sticky=1, jobs_done unchanged.
6. Reset during RUN → acc_start=0 asynchronously. After release, a pending req1 is granted with rr_last back at its reset value.

Source files
------------

// File: rtl/fir_ctrl_pkg.sv
// rtl/fir_ctrl_pkg.sv - shared state encoding and defaults for the FIR job arbiter
package fir_ctrl_pkg;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_START   = 5'b00010,
    ST_RUN     = 5'b00100,
    ST_RELEASE = 5'b01000,
    ST_DONE    = 5'b10000
  } fir_state_t;

  localparam int BLANK_CYCLES_DEF   = 3;
  localparam int TIMEOUT_CYCLES_DEF = 65535;
  localparam int CNT_W_DEF          = 16;

endpackage

// File: rtl/fir_rr_arb.sv
// rtl/fir_rr_arb.sv - two-input round-robin pick
// rr_last names the requester served last; on a tie the other one wins.
module fir_rr_arb (
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic [1:0] gnt,
  output logic       valid
);

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = rr_last ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
    valid = |req;
  end

endmodule

// File: rtl/fir_job_arbiter.sv
// rtl/fir_job_arbiter.sv - shares one FIR accelerator between two start/done requesters
// Blanks the accelerator's stale finish after start and aborts hung jobs via a watchdog.
module fir_job_arbiter
  import fir_ctrl_pkg::*;
#(
  parameter int BLANK_CYCLES   = BLANK_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_start,
  output logic             req0_done,
  input  logic             req1_start,
  output logic             req1_done,
  output logic             acc_start,
  input  logic             acc_finish,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             job_err,
  output logic             timeout_sticky,
  output logic [CNT_W-1:0] jobs_done
);

  localparam int BL_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [BL_W-1:0] BLANK_LAST = BL_W'(BLANK_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);

  fir_state_t      state;
  logic            rr_last;
  logic            err_q;
  logic [BL_W-1:0] blank_cnt;
  logic [WD_W-1:0] wd_cnt;
  logic [1:0]      arb_gnt;
  logic            arb_valid;
  logic            owner_start;
  logic            wd_expired;

  fir_rr_arb u_arb (
    .req     ({req1_start, req0_start}),
    .rr_last (rr_last),
    .gnt     (arb_gnt),
    .valid   (arb_valid)
  );

  assign owner_start = grant[1] ? req1_start : req0_start;
  assign wd_expired  = (wd_cnt == WD_LAST);
  assign busy        = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      acc_start      <= 1'b0;
      req0_done      <= 1'b0;
      req1_done      <= 1'b0;
      grant          <= 2'b00;
      job_err        <= 1'b0;
      err_q          <= 1'b0;
      timeout_sticky <= 1'b0;
      jobs_done      <= '0;
      rr_last        <= 1'b1;
      blank_cnt      <= '0;
      wd_cnt         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            grant     <= arb_gnt;
            acc_start <= 1'b1;
            blank_cnt <= '0;
            wd_cnt    <= '0;
            state     <= ST_START;
          end
        end
        // acc_finish is deliberately not looked at here: it may still be the previous job's.
        ST_START: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (wd_expired) begin
            acc_start      <= 1'b0;
            err_q          <= 1'b1;
            timeout_sticky <= 1'b1;
            state          <= ST_RELEASE;
          end else if (blank_cnt == BLANK_LAST) begin
            state <= ST_RUN;
          end else begin
            blank_cnt <= blank_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (acc_finish) begin
            acc_start <= 1'b0;
            err_q     <= 1'b0;
            jobs_done <= jobs_done + 1'b1;
            state     <= ST_RELEASE;
          end else if (wd_expired) begin
            acc_start      <= 1'b0;
            err_q          <= 1'b1;
            timeout_sticky <= 1'b1;
            state          <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          req0_done <= grant[0];
          req1_done <= grant[1];
          job_err   <= err_q;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (!owner_start) begin
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            job_err   <= 1'b0;
            grant     <= 2'b00;
            rr_last   <= grant[1];
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_job_arbiter.sv
// tb/tb_fir_job_arbiter.sv - directed self-checking bench for fir_job_arbiter
module tb_fir_job_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_start, req1_start, acc_finish;
  logic        req0_done, req1_done, acc_start, busy, job_err, timeout_sticky;
  logic [1:0]  grant;
  logic [15:0] jobs_done;

  logic        t_req1_start;
  logic        t_req0_done, t_req1_done, t_acc_start, t_busy, t_job_err, t_timeout_sticky;
  logic [1:0]  t_grant;
  logic [15:0] t_jobs_done;

  int checks = 0;
  int errors = 0;

  int fin_delay = 300;
  bit stale = 0;
  int hi_cnt = 0;
  int hi_max = 0;

  fir_job_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .req0_start     (req0_start),
    .req0_done      (req0_done),
    .req1_start     (req1_start),
    .req1_done      (req1_done),
    .acc_start      (acc_start),
    .acc_finish     (acc_finish),
    .grant          (grant),
    .busy           (busy),
    .job_err        (job_err),
    .timeout_sticky (timeout_sticky),
    .jobs_done      (jobs_done)
  );

  fir_job_arbiter #(.TIMEOUT_CYCLES(50)) dut_to (
    .clk            (clk),
    .reset          (reset),
    .req0_start     (1'b0),
    .req0_done      (t_req0_done),
    .req1_start     (t_req1_start),
    .req1_done      (t_req1_done),
    .acc_start      (t_acc_start),
    .acc_finish     (1'b0),
    .grant          (t_grant),
    .busy           (t_busy),
    .job_err        (t_job_err),
    .timeout_sticky (t_timeout_sticky),
    .jobs_done      (t_jobs_done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Accelerator model: finish fin_delay cycles after start, held until start drops.
  // In stale mode finish is high while idle and clears 2 cycles after the accelerator sees start.
  initial begin
    acc_finish = 0;
    forever begin
      @(negedge clk);
      if (acc_start) begin
        hi_cnt++;
        hi_max = hi_cnt;
        if (stale && hi_cnt == 3) begin
          stale = 0;
          acc_finish = 0;
        end
        if (fin_delay != 0 && hi_cnt >= fin_delay) acc_finish = 1;
      end else begin
        hi_cnt = 0;
        acc_finish = stale;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout sim time exceeded");
    $fatal(1, "bench hung");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_start(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (acc_start) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input bit which, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (which ? req1_done : req0_done) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 0; req0_start = 1; req1_start = 0; t_req1_start = 0;
    tick(3);
    checks++;
    if ({acc_start, req0_done, req1_done, grant, busy, job_err, timeout_sticky} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=%b",
               {acc_start, req0_done, req1_done, grant, busy, job_err, timeout_sticky}, 8'b0);
    end
    checks++;
    if (jobs_done !== 16'd0) begin
      errors++;
      $display("FAIL reset_jobs_done got=%0d exp=0", jobs_done);
    end
    reset = 1;
    tick(2);
    checks++;
    if (acc_start !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_start got=%b exp=1", acc_start);
    end
    checks++;
    if (grant !== 2'b01) begin
      errors++;
      $display("FAIL reset_first_grant got=%b exp=01", grant);
    end
  endtask

  task automatic test_single_job;
    bit ok;
    wait_done(0, 400, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_done_wait got=timeout exp=req0_done");
    end
    checks++;
    if (hi_max !== 300) begin
      errors++;
      $display("FAIL single_start_len got=%0d exp=300", hi_max);
    end
    tick(5);
    checks++;
    if ({req0_done, job_err, acc_start, busy} !== 4'b1001) begin
      errors++;
      $display("FAIL single_done_hold got=%b exp=1001", {req0_done, job_err, acc_start, busy});
    end
    checks++;
    if (jobs_done !== 16'd1) begin
      errors++;
      $display("FAIL single_jobs_done got=%0d exp=1", jobs_done);
    end
    req0_start = 0;
    tick(1);
    checks++;
    if ({req0_done, busy, grant} !== 4'b0000) begin
      errors++;
      $display("FAIL single_release got=%b exp=0000", {req0_done, busy, grant});
    end
  endtask

  task automatic test_stale_finish;
    bit ok;
    stale = 1;
    tick(2);
    req0_start = 1;
    wait_start(10, ok);
    tick(10);
    checks++;
    if ({ok, acc_start, busy} !== 3'b111 || jobs_done !== 16'd1) begin
      errors++;
      $display("FAIL stale_early_finish got=%b/%0d exp=111/1", {ok, acc_start, busy}, jobs_done);
    end
    wait_done(0, 400, ok);
    checks++;
    if (!ok || hi_max !== 300) begin
      errors++;
      $display("FAIL stale_real_finish got=%b/%0d exp=1/300", ok, hi_max);
    end
    checks++;
    if (jobs_done !== 16'd2 || job_err !== 1'b0) begin
      errors++;
      $display("FAIL stale_jobs_done got=%0d/%b exp=2/0", jobs_done, job_err);
    end
    req0_start = 0;
    tick(2);
  endtask

  task automatic test_contention;
    bit ok;
    logic [1:0] exp_g;
    reset = 0; fin_delay = 20;
    req0_start = 1; req1_start = 1;
    tick(2);
    reset = 1;
    for (int j = 0; j < 4; j++) begin
      exp_g = (j % 2 == 0) ? 2'b01 : 2'b10;
      wait_start(20, ok);
      checks++;
      if (!ok || grant !== exp_g) begin
        errors++;
        $display("FAIL contention_grant%0d got=%b/%b exp=1/%b", j, ok, grant, exp_g);
      end
      wait_done(exp_g[1], 100, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL contention_done%0d got=timeout exp=done", j);
      end
      if (j == 3) begin
        req0_start = 0; req1_start = 0;
      end else begin
        if (exp_g[1]) req1_start = 0; else req0_start = 0;
        tick(1);
        if (exp_g[1]) req1_start = 1; else req0_start = 1;
      end
    end
    tick(3);
    checks++;
    if (jobs_done !== 16'd4 || busy !== 1'b0 || timeout_sticky !== 1'b0) begin
      errors++;
      $display("FAIL contention_total got=%0d/%b/%b exp=4/0/0", jobs_done, busy, timeout_sticky);
    end
  endtask

  task automatic test_timeout;
    int cnt;
    t_req1_start = 1;
    for (int i = 0; i < 10 && !t_acc_start; i++) tick(1);
    cnt = 0;
    while (t_acc_start && cnt < 200) begin
      cnt++;
      tick(1);
    end
    checks++;
    if (cnt !== 50) begin
      errors++;
      $display("FAIL timeout_len got=%0d exp=50", cnt);
    end
    for (int i = 0; i < 10 && !t_req1_done; i++) tick(1);
    checks++;
    if ({t_req1_done, t_job_err, t_timeout_sticky, t_grant} !== 5'b11110) begin
      errors++;
      $display("FAIL timeout_done got=%b exp=11110", {t_req1_done, t_job_err, t_timeout_sticky, t_grant});
    end
    checks++;
    if (t_jobs_done !== 16'd0) begin
      errors++;
      $display("FAIL timeout_jobs_done got=%0d exp=0", t_jobs_done);
    end
    t_req1_start = 0;
    tick(2);
    checks++;
    if ({t_req1_done, t_job_err, t_timeout_sticky, t_busy} !== 4'b0010) begin
      errors++;
      $display("FAIL timeout_release got=%b exp=0010", {t_req1_done, t_job_err, t_timeout_sticky, t_busy});
    end
  endtask

  task automatic test_reset_mid_run;
    bit ok;
    req0_start = 1;
    wait_done(0, 100, ok);
    req0_start = 0;
    tick(2);
    req1_start = 1;
    wait_start(10, ok);
    tick(8);
    req0_start = 1;
    @(posedge clk);
    #2 reset = 0;
    #1;
    checks++;
    if ({acc_start, busy, grant} !== 4'b0000) begin
      errors++;
      $display("FAIL midrun_async got=%b exp=0000", {acc_start, busy, grant});
    end
    tick(2);
    reset = 1;
    wait_start(10, ok);
    checks++;
    if (!ok || grant !== 2'b01 || jobs_done !== 16'd0) begin
      errors++;
      $display("FAIL midrun_first_grant got=%b/%b/%0d exp=1/01/0", ok, grant, jobs_done);
    end
    wait_done(0, 100, ok);
    req0_start = 0;
    tick(1);
    wait_start(10, ok);
    checks++;
    if (!ok || grant !== 2'b10) begin
      errors++;
      $display("FAIL midrun_req1_grant got=%b/%b exp=1/10", ok, grant);
    end
    wait_done(1, 100, ok);
    req1_start = 0;
    tick(2);
    checks++;
    if (!ok || jobs_done !== 16'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_total got=%b/%0d/%b exp=1/2/0", ok, jobs_done, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_stale_finish();
    test_contention();
    test_timeout();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
